// File: rtl/cache_ctrl_wb.sv
// Write-back, write-allocate data-cache controller FSM with a configurable
// memory-latency down-counter, fill-then-merge byte stores and saturating stats.
module cache_ctrl_wb #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16,
  parameter int LAT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             cache_hit,
  input  logic             cache_dirty,
  output logic             we_memory,
  output logic             we_cache,
  output logic             cache_input_type,
  output logic             memory_address_type,
  output logic             is_word,
  output logic             register_write,
  output logic             set_dirty,
  output logic             set_valid,
  output logic             pc_enable,
  output logic             busy,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count,
  output logic [2:0]       dbg_state
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    FILL    = 3'd2,
    FILL_WR = 3'd3,
    MERGE   = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [LAT_W-1:0] cnt, cnt_n;
  logic [5:0]       op_q, op_n;
  logic [5:0]       op;
  logic             is_mem, is_load;
  logic             hit_inc, miss_inc, wb_inc;

  assign dbg_state = state;

  // The live opcode only matters in IDLE; once a miss starts, op_q drives everything.
  assign op      = (state == IDLE) ? opcode : op_q;
  assign is_load = (op == OP_LW) || (op == OP_LB);
  assign is_mem  = is_load || (op == OP_SW) || (op == OP_SB);

  // Stall protocol: pc_enable=0 holds the PC/pipeline; the CPU re-presents nothing,
  // the controller completes the access from op_q and raises pc_enable when done.
  always_comb begin
    state_n             = state;
    cnt_n               = cnt;
    op_n                = op_q;
    hit_inc             = 1'b0;
    miss_inc            = 1'b0;
    wb_inc              = 1'b0;
    we_memory           = 1'b0;
    we_cache            = 1'b0;
    cache_input_type    = 1'b1;
    memory_address_type = 1'b0;
    is_word             = (op == OP_LW) || (op == OP_SW);
    register_write      = 1'b0;
    set_dirty           = 1'b0;
    set_valid           = 1'b0;
    pc_enable           = 1'b0;
    busy                = (state != IDLE);

    case (state)
      IDLE: begin
        if (!is_mem) begin
          pc_enable = 1'b1;
        end else if (cache_hit) begin
          hit_inc = 1'b1;
          pc_enable = 1'b1;
          if (is_load) begin
            register_write = 1'b1;
          end else begin
            we_cache  = 1'b1;
            set_dirty = 1'b1;
            set_valid = 1'b1;
          end
        end else if (cache_dirty) begin
          miss_inc            = 1'b1;
          wb_inc              = 1'b1;
          we_memory           = 1'b1;
          memory_address_type = 1'b1;
          op_n                = opcode;
          cnt_n               = LAT_RELOAD;
          state_n             = WB;
        end else if (op == OP_SW) begin
          // Full-word store over a clean line needs no fill.
          miss_inc  = 1'b1;
          we_cache  = 1'b1;
          set_dirty = 1'b1;
          set_valid = 1'b1;
          pc_enable = 1'b1;
        end else begin
          miss_inc = 1'b1;
          op_n     = opcode;
          cnt_n    = LAT_RELOAD;
          state_n  = FILL;
        end
      end
      WB: begin
        memory_address_type = 1'b1;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (op_q == OP_SW) begin
          state_n = MERGE;
        end else begin
          cnt_n   = LAT_RELOAD;
          state_n = FILL;
        end
      end
      FILL: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else           state_n = FILL_WR;
      end
      FILL_WR: begin
        we_cache         = 1'b1;
        cache_input_type = 1'b0;
        is_word          = 1'b1;
        set_valid        = 1'b1;
        state_n          = (op_q == OP_SB) ? MERGE : RESP;
      end
      MERGE: begin
        we_cache  = 1'b1;
        set_dirty = 1'b1;
        set_valid = 1'b1;
        pc_enable = 1'b1;
        state_n   = IDLE;
      end
      RESP: begin
        register_write = 1'b1;
        pc_enable      = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Reset silences every strobe so nothing is written in the reset cycle.
    if (reset) begin
      hit_inc             = 1'b0;
      miss_inc            = 1'b0;
      wb_inc              = 1'b0;
      we_memory           = 1'b0;
      we_cache            = 1'b0;
      cache_input_type    = 1'b0;
      memory_address_type = 1'b0;
      is_word             = 1'b0;
      register_write      = 1'b0;
      set_dirty           = 1'b0;
      set_valid           = 1'b0;
      pc_enable           = 1'b0;
      busy                = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      if (hit_inc && (hit_count != '1))   hit_count  <= hit_count + CNT_W'(1);
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
      if (wb_inc && (wb_count != '1))     wb_count   <= wb_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Table-driven bench for cache_ctrl_wb: per-cycle vectors for the main instance
// (MEM_LATENCY=4) plus hand sequences on a MEM_LATENCY=1, CNT_W=2 instance.
module tb_cache_ctrl_wb;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] NOP = 6'b000000;

  localparam logic [2:0] S_IDLE = 3'd0, S_WB = 3'd1, S_FILL = 3'd2,
                         S_FILL_WR = 3'd3, S_MERGE = 3'd4, S_RESP = 3'd5;

  // ctl bit order: we_memory we_cache cache_input_type memory_address_type
  //                is_word register_write set_dirty set_valid pc_enable busy
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       hit;
    logic       dirty;
    logic [9:0] ctl;
    logic [2:0] st;
    logic       chk;
    int         h;
    int         m;
    int         w;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = NOP;
  logic cache_hit = 1'b0;
  logic cache_dirty = 1'b0;

  logic we_memory, we_cache, cache_input_type, memory_address_type, is_word;
  logic register_write, set_dirty, set_valid, pc_enable, busy;
  logic [15:0] hit_count, miss_count, wb_count;
  logic [2:0] dbg_state;

  logic s_we_memory, s_we_cache, s_cache_input_type, s_memory_address_type, s_is_word;
  logic s_register_write, s_set_dirty, s_set_valid, s_pc_enable, s_busy;
  logic [1:0] s_hit_count, s_miss_count, s_wb_count;
  logic [2:0] s_dbg_state;

  int total = 0;
  int passed = 0;
  step_t steps[$];

  always #5 clk = ~clk;

  cache_ctrl_wb #(.MEM_LATENCY(4), .CNT_W(16), .LAT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cache_hit(cache_hit),
    .cache_dirty(cache_dirty), .we_memory(we_memory), .we_cache(we_cache),
    .cache_input_type(cache_input_type), .memory_address_type(memory_address_type),
    .is_word(is_word), .register_write(register_write), .set_dirty(set_dirty),
    .set_valid(set_valid), .pc_enable(pc_enable), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
    .dbg_state(dbg_state)
  );

  cache_ctrl_wb #(.MEM_LATENCY(1), .CNT_W(2), .LAT_W(8)) u_small (
    .clk(clk), .reset(reset), .opcode(opcode), .cache_hit(cache_hit),
    .cache_dirty(cache_dirty), .we_memory(s_we_memory), .we_cache(s_we_cache),
    .cache_input_type(s_cache_input_type), .memory_address_type(s_memory_address_type),
    .is_word(s_is_word), .register_write(s_register_write), .set_dirty(s_set_dirty),
    .set_valid(s_set_valid), .pc_enable(s_pc_enable), .busy(s_busy),
    .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count),
    .dbg_state(s_dbg_state)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic hit,
                     input logic dirty, input logic [9:0] ctl, input logic [2:0] st,
                     input logic chk, input int h, input int m, input int w);
    step_t s;
    s.rst = rst; s.op = op; s.hit = hit; s.dirty = dirty; s.ctl = ctl;
    s.st = st; s.chk = chk; s.h = h; s.m = m; s.w = w;
    steps.push_back(s);
  endtask

  task automatic drive(input logic rst, input logic [5:0] op, input logic hit,
                       input logic dirty);
    @(posedge clk);
    #1;
    reset = rst; opcode = op; cache_hit = hit; cache_dirty = dirty;
  endtask

  initial begin
    // IDLE single-cycle decisions; first row is the reset-cycle output check
    add(1, LW,  1, 0, 10'b0000000000, S_IDLE, 1, 0, 0, 0);
    add(0, NOP, 0, 0, 10'b0010000010, S_IDLE, 1, 0, 0, 0);
    add(0, LW,  1, 0, 10'b0010110010, S_IDLE, 1, 0, 0, 0);
    add(0, SW,  1, 1, 10'b0110101110, S_IDLE, 1, 1, 0, 0);
    add(0, LB,  1, 0, 10'b0010010010, S_IDLE, 1, 2, 0, 0);
    add(0, SB,  1, 0, 10'b0110001110, S_IDLE, 1, 3, 0, 0);
    add(0, SW,  0, 0, 10'b0110101110, S_IDLE, 1, 4, 0, 0);
    add(0, NOP, 1, 1, 10'b0010000010, S_IDLE, 1, 4, 1, 0);

    // LW miss clean; SW+hit driven during FILL must be ignored
    add(1, NOP, 0, 0, 10'b0000000000, S_IDLE, 1, 4, 1, 0);
    add(0, LW,  0, 0, 10'b0010100000, S_IDLE, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, SW, 1, 0, 10'b0010100001, S_FILL, 1, 0, 1, 0);
    add(0, NOP, 0, 0, 10'b0100100101, S_FILL_WR, 1, 0, 1, 0);
    add(0, NOP, 0, 0, 10'b0010110011, S_RESP, 1, 0, 1, 0);
    add(0, NOP, 0, 0, 10'b0010000010, S_IDLE, 1, 0, 1, 0);

    // LB miss dirty: writeback, fill, response
    add(1, NOP, 0, 0, 10'b0000000000, S_IDLE, 1, 0, 1, 0);
    add(0, LB,  0, 1, 10'b1011000000, S_IDLE, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, NOP, 0, 1, 10'b0011000001, S_WB, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) add(0, NOP, 0, 0, 10'b0010000001, S_FILL, 1, 0, 1, 1);
    add(0, NOP, 0, 0, 10'b0100100101, S_FILL_WR, 1, 0, 1, 1);
    add(0, NOP, 0, 0, 10'b0010010011, S_RESP, 1, 0, 1, 1);
    add(0, NOP, 0, 0, 10'b0010000010, S_IDLE, 1, 0, 1, 1);

    // SB miss clean: fill then merge
    add(1, NOP, 0, 0, 10'b0000000000, S_IDLE, 1, 0, 1, 1);
    add(0, SB,  0, 0, 10'b0010000000, S_IDLE, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, NOP, 0, 0, 10'b0010000001, S_FILL, 1, 0, 1, 0);
    add(0, NOP, 0, 0, 10'b0100100101, S_FILL_WR, 1, 0, 1, 0);
    add(0, NOP, 0, 0, 10'b0110001111, S_MERGE, 1, 0, 1, 0);
    add(0, NOP, 0, 0, 10'b0010000010, S_IDLE, 1, 0, 1, 0);

    // SW miss dirty: writeback then merge, no fill
    add(1, NOP, 0, 0, 10'b0000000000, S_IDLE, 1, 0, 1, 0);
    add(0, SW,  0, 1, 10'b1011100000, S_IDLE, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, NOP, 0, 0, 10'b0011100001, S_WB, 1, 0, 1, 1);
    add(0, NOP, 0, 0, 10'b0110101111, S_MERGE, 1, 0, 1, 1);
    add(0, NOP, 0, 0, 10'b0010000010, S_IDLE, 1, 0, 1, 1);

    // Reset in cycle 3 of a fill aborts it
    add(1, NOP, 0, 0, 10'b0000000000, S_IDLE, 1, 0, 1, 1);
    add(0, LW,  0, 0, 10'b0010100000, S_IDLE, 1, 0, 0, 0);
    add(0, NOP, 0, 0, 10'b0010100001, S_FILL, 1, 0, 1, 0);
    add(1, NOP, 0, 0, 10'b0000000000, S_FILL, 1, 0, 1, 0);
    add(0, NOP, 0, 0, 10'b0010000010, S_IDLE, 1, 0, 0, 0);
    add(0, NOP, 0, 0, 10'b0010000010, S_IDLE, 1, 0, 0, 0);

    reset = 1'b1;
    repeat (2) @(posedge clk);

    foreach (steps[i]) begin
      drive(steps[i].rst, steps[i].op, steps[i].hit, steps[i].dirty);
      @(negedge clk);
      check("ctl", i, 32'({we_memory, we_cache, cache_input_type, memory_address_type,
                           is_word, register_write, set_dirty, set_valid, pc_enable,
                           busy}), 32'(steps[i].ctl));
      check("state", i, 32'(dbg_state), 32'(steps[i].st));
      if (steps[i].chk) begin
        check("hit_count", i, 32'(hit_count), 32'(steps[i].h));
        check("miss_count", i, 32'(miss_count), 32'(steps[i].m));
        check("wb_count", i, 32'(wb_count), 32'(steps[i].w));
      end
    end

    // Saturation: five hits on the CNT_W=2 instance stop at 3
    drive(1, NOP, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, LW, 1, 0);
    drive(0, NOP, 0, 0);
    @(negedge clk);
    check("sat_hit_count", 0, 32'(s_hit_count), 32'd3);
    check("main_hit_count", 0, 32'(hit_count), 32'd5);

    // MEM_LATENCY=1 dirty load miss: WB and FILL one cycle each, pc_enable in cycle 5
    drive(1, NOP, 0, 0);
    drive(0, LW, 0, 1);
    @(negedge clk);
    check("l1_c1_state", 1, 32'(s_dbg_state), 32'(S_IDLE));
    check("l1_c1_we_memory", 1, 32'(s_we_memory), 32'd1);
    drive(0, NOP, 0, 0);
    @(negedge clk);
    check("l1_c2_state", 2, 32'(s_dbg_state), 32'(S_WB));
    check("l1_c2_pc_enable", 2, 32'(s_pc_enable), 32'd0);
    drive(0, NOP, 0, 0);
    @(negedge clk);
    check("l1_c3_state", 3, 32'(s_dbg_state), 32'(S_FILL));
    drive(0, NOP, 0, 0);
    @(negedge clk);
    check("l1_c4_state", 4, 32'(s_dbg_state), 32'(S_FILL_WR));
    check("l1_c4_we_cache", 4, 32'(s_we_cache), 32'd1);
    drive(0, NOP, 0, 0);
    @(negedge clk);
    check("l1_c5_state", 5, 32'(s_dbg_state), 32'(S_RESP));
    check("l1_c5_pc_rw", 5, 32'({s_pc_enable, s_register_write}), 32'd3);
    drive(0, NOP, 0, 0);
    @(negedge clk);
    check("l1_c6_state", 6, 32'(s_dbg_state), 32'(S_IDLE));
    check("l1_miss_count", 6, 32'(s_miss_count), 32'd1);
    check("l1_wb_count", 6, 32'(s_wb_count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
